// File: rtl/psum_sram_accum_if.sv
// Request, drain and status signals of the partial-sum accumulator.
// The master side (MAC array / drain consumer) drives requests; the slave side is the accumulator.
interface psum_sram_accum_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 19,
    parameter int ADDR_W = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_first;
    logic [ADDR_W-1:0]         in_addr;
    logic [LANES*LANE_W-1:0]   in_data;
    logic                      drain_start;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*LANE_W-1:0]   out_data;
    logic                      drain_done;
    logic                      busy;
    logic                      sat_flag;

    modport master (
        output in_valid, in_first, in_addr, in_data, drain_start, out_ready,
        input  in_ready, out_valid, out_data, drain_done, busy, sat_flag
    );

    modport slave (
        input  in_valid, in_first, in_addr, in_data, drain_start, out_ready,
        output in_ready, out_valid, out_data, drain_done, busy, sat_flag
    );
endinterface

// File: rtl/psum_sram_accum.sv
// Read-modify-write saturating accumulator in front of a single-port partial-sum SRAM,
// with a full sequential drain of every entry to the output path.
module psum_sram_accum #(
    parameter int LANES  = 8,
    parameter int LANE_W = 19,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    psum_sram_accum_if.slave        bus,
    output logic                    sram_cen,
    output logic                    sram_wen,
    output logic [ADDR_W-1:0]       sram_a,
    output logic [LANES*LANE_W-1:0] sram_d,
    input  logic [LANES*LANE_W-1:0] sram_q
);
    localparam int WORD_W = LANES * LANE_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        DR_RD  = 3'd3,
        DR_OUT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                first_q, first_d;
    logic                sat_q, sat_d;
    logic                done_q, done_d;

    logic                accept;
    logic                drain_go;
    logic                last_word;
    logic [WORD_W-1:0]   sum_word;
    logic [LANES-1:0]    lane_sat;

    assign bus.in_ready   = (state_q == IDLE) && !bus.drain_start;
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_data   = sram_q;
    assign bus.drain_done = done_q;
    assign bus.sat_flag   = sat_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign drain_go  = (state_q == IDLE) && bus.drain_start;
    assign last_word = (cnt_q == ADDR_W'(DEPTH - 1));

    // Per-lane signed add one bit wider; a sign mismatch in the top two bits means overflow.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [LANE_W-1:0] lane_a;
            logic signed [LANE_W-1:0] lane_b;
            logic signed [LANE_W:0]   lane_sum;
            logic                     lane_ovf;

            assign lane_a   = sram_q[gi*LANE_W +: LANE_W];
            assign lane_b   = data_q[gi*LANE_W +: LANE_W];
            assign lane_sum = {lane_a[LANE_W-1], lane_a} + {lane_b[LANE_W-1], lane_b};
            assign lane_ovf = lane_sum[LANE_W] ^ lane_sum[LANE_W-1];
            assign lane_sat[gi] = lane_ovf;
            assign sum_word[gi*LANE_W +: LANE_W] =
                !lane_ovf         ? lane_sum[LANE_W-1:0] :
                lane_sum[LANE_W]  ? {1'b1, {(LANE_W-1){1'b0}}} :
                                    {1'b0, {(LANE_W-1){1'b1}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (drain_go) begin
                    state_d = DR_RD;
                end else if (accept) begin
                    state_d = bus.in_first ? WR : RD;
                end
            end
            RD:     state_d = WR;
            WR:     state_d = IDLE;
            DR_RD:  state_d = DR_OUT;
            DR_OUT: begin
                if (bus.out_ready) begin
                    state_d = last_word ? IDLE : DR_RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM pins idle (CEN high) everywhere except the three access states.
    always_comb begin
        sram_cen      = 1'b1;
        sram_wen      = 1'b1;
        sram_a        = addr_q;
        sram_d        = data_q;
        bus.out_valid = 1'b0;
        case (state_q)
            RD: begin
                sram_cen = 1'b0;
            end
            WR: begin
                sram_cen = 1'b0;
                sram_wen = 1'b0;
                sram_d   = first_q ? data_q : sum_word;
            end
            DR_RD: begin
                sram_cen = 1'b0;
                sram_a   = cnt_q;
            end
            DR_OUT: begin
                bus.out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        if (accept) begin
            addr_d  = bus.in_addr;
            data_d  = bus.in_data;
            first_d = bus.in_first;
        end
        if (drain_go) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
        if ((state_q == WR) && !first_q && (|lane_sat)) begin
            sat_d = 1'b1;
        end
        if ((state_q == DR_OUT) && bus.out_ready) begin
            if (last_word) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    // Holding registers need no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        data_q  <= data_d;
        first_q <= first_d;
        if (reset) begin
            cnt_q  <= '0;
            sat_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_psum_sram_accum.sv
// Randomized and directed bench for psum_sram_accum against a lane-level reference model
// and a behavioural single-port SRAM.
module tb_psum_sram_accum;
    localparam int LANES  = 8;
    localparam int LANE_W = 19;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int W      = LANES * LANE_W;
    localparam int SMAX   = 262143;
    localparam int SMIN   = -262144;

    typedef int lanes_t [LANES];

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    psum_sram_accum_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus ();

    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [W-1:0]      sram_d;
    logic [W-1:0]      sram_q;

    psum_sram_accum #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sram_cen (sram_cen),
        .sram_wen (sram_wen),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_q   (sram_q)
    );

    // Behavioural SRAM: Q updates only on a read edge and holds otherwise.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q <= mem[sram_a];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    lanes_t            ref_mem [DEPTH];
    logic [W-1:0]      exp_out_q [$];
    logic [W-1:0]      exp_wd_q  [$];
    logic [ADDR_W-1:0] exp_wa_q  [$];
    logic [ADDR_W-1:0] exp_ra_q  [$];
    logic [W-1:0]      drained [DEPTH];
    int                drain_idx = 0;
    int                done_cnt  = 0;
    bit                sat_exp   = 1'b0;
    logic              prev_stall = 1'b0;
    logic [W-1:0]      prev_data;

    function automatic logic [W-1:0] pack(input lanes_t v);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < LANES; i++) w[i*LANE_W +: LANE_W] = v[i][LANE_W-1:0];
        return w;
    endfunction

    function automatic int lane_of(input logic [W-1:0] w, input int i);
        logic signed [LANE_W-1:0] x;
        x = w[i*LANE_W +: LANE_W];
        return int'(x);
    endfunction

    function automatic lanes_t splat(input int v);
        lanes_t r;
        for (int i = 0; i < LANES; i++) r[i] = v;
        return r;
    endfunction

    function automatic int rnd_lane();
        int k;
        k = int'($urandom_range(0, 3));
        if (k == 0) return SMAX - int'($urandom_range(0, 3000));
        if (k == 1) return SMIN + int'($urandom_range(0, 3000));
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic flag_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // Cycle-by-cycle compare of SRAM traffic, drain words, done pulses and the sticky flag.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (!sram_cen) begin
                if (sram_wen) begin
                    if (exp_ra_q.size() == 0) flag_fail("sram_unexpected_read");
                    else chk("sram_read_addr", W'(sram_a), W'(exp_ra_q.pop_front()));
                end else begin
                    if (exp_wa_q.size() == 0) flag_fail("sram_unexpected_write");
                    else begin
                        chk("sram_write_addr", W'(sram_a), W'(exp_wa_q.pop_front()));
                        chk("sram_write_data", sram_d, exp_wd_q.pop_front());
                    end
                end
            end
            if (bus.out_valid) begin
                if (exp_out_q.size() == 0) flag_fail("out_valid_unexpected");
                else begin
                    chk("out_data", bus.out_data, exp_out_q[0]);
                    if (prev_stall) chk("out_data_stall_stable", bus.out_data, prev_data);
                    if (bus.out_ready) begin
                        if (drain_idx < DEPTH) drained[drain_idx] = bus.out_data;
                        drain_idx++;
                        void'(exp_out_q.pop_front());
                    end
                end
            end
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_data  <= bus.out_data;
            if (bus.drain_done) begin
                done_cnt++;
                chk_int("drain_done_after_last", exp_out_q.size(), 0);
            end
            if (!bus.busy) chk("sat_flag", W'(bus.sat_flag), W'(sat_exp));
        end
    end

    task automatic submit(input int addr, input bit first, input lanes_t v, input bit upd,
                          input bit drain_in_rd, input bit reset_in_rd, output int low_cycles);
        lanes_t nv;
        bit     acc;
        bit     sat_hit;
        int     tmo;
        int     s;
        sat_hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (first) nv[i] = v[i];
            else begin
                s = ref_mem[addr][i] + v[i];
                if (s > SMAX) begin s = SMAX; sat_hit = 1'b1; end
                else if (s < SMIN) begin s = SMIN; sat_hit = 1'b1; end
                nv[i] = s;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_addr  = ADDR_W'(addr);
        bus.in_data  = pack(v);
        acc = 1'b0;
        tmo = 0;
        while (!acc && tmo < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            tmo++;
        end
        bus.in_valid = 1'b0;
        low_cycles = 0;
        if (!acc) begin
            flag_fail("request_accept_timeout");
            return;
        end
        if (reset_in_rd) begin
            reset = 1'b1;
            sat_exp = 1'b0;
            @(posedge clk);
            #1;
            chk("reset_in_rd_cen", W'(sram_cen), W'(1));
            chk("reset_in_rd_busy", W'(bus.busy), W'(0));
            reset = 1'b0;
            return;
        end
        if (upd) begin
            if (!first) exp_ra_q.push_back(ADDR_W'(addr));
            exp_wa_q.push_back(ADDR_W'(addr));
            exp_wd_q.push_back(pack(nv));
            ref_mem[addr] = nv;
            if (sat_hit) sat_exp = 1'b1;
        end
        if (drain_in_rd) begin
            bus.drain_start = 1'b1;
            @(posedge clk);
            #1;
            bus.drain_start = 1'b0;
            low_cycles = 1;
        end
        tmo = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            low_cycles++;
            if (++tmo > 50) begin
                flag_fail("return_to_idle_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: out_ready held high, 1: periodic 1/1/0 pattern, 2: random.
    task automatic drain(input int mode, input bit req_pending, output int cycles, output int acc_during);
        int d0;
        for (int e = 0; e < DEPTH; e++) begin
            exp_out_q.push_back(pack(ref_mem[e]));
            exp_ra_q.push_back(ADDR_W'(e));
        end
        drain_idx  = 0;
        d0         = done_cnt;
        acc_during = 0;
        bus.out_ready   = 1'b1;
        bus.drain_start = 1'b1;
        @(posedge clk);
        #1;
        bus.drain_start = 1'b0;
        sat_exp = 1'b0;
        cycles = 0;
        forever begin
            if (mode == 1)      bus.out_ready = ((cycles % 3) != 1);
            else if (mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
            else                bus.out_ready = 1'b1;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc_during++;
            @(posedge clk);
            cycles++;
            #1;
            if (bus.drain_done) break;
            if (cycles > 400) begin
                flag_fail("drain_done_timeout");
                break;
            end
        end
        bus.out_ready = 1'b1;
        if (!req_pending) begin
            @(posedge clk);
            #1;
            chk_int("drain_done_pulse_count", done_cnt - d0, 1);
            chk("drain_done_one_cycle", W'(bus.drain_done), W'(0));
        end
        chk_int("drain_words_remaining", exp_out_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     lc;
        int     cyc;
        int     acc;
        lanes_t v;
        for (int e = 0; e < DEPTH; e++) ref_mem[e] = splat(0);
        bus.in_valid    = 1'b0;
        bus.in_first    = 1'b0;
        bus.in_addr     = '0;
        bus.in_data     = '0;
        bus.drain_start = 1'b0;
        bus.out_ready   = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cen", W'(sram_cen), W'(1));
        chk("reset_wen", W'(sram_wen), W'(1));
        chk("reset_out_valid", W'(bus.out_valid), W'(0));
        chk("reset_drain_done", W'(bus.drain_done), W'(0));
        chk("reset_sat_flag", W'(bus.sat_flag), W'(0));
        chk("reset_busy", W'(bus.busy), W'(0));
        reset = 1'b0;
        chk("idle_in_ready", W'(bus.in_ready), W'(1));

        for (int e = 0; e < DEPTH; e++) submit(e, 1'b1, splat(0), 1'b1, 1'b0, 1'b0, lc);

        // First-write then drain: word 3 holds 5 in every lane.
        submit(3, 1'b1, splat(5), 1'b1, 1'b0, 1'b0, lc);
        chk_int("first_write_ready_low", lc, 1);
        drain(0, 1'b0, cyc, acc);
        chk_int("drain_cycles_full_rate", cyc, 32);
        for (int i = 0; i < LANES; i++) chk_int("word3_first_lane", lane_of(drained[3], i), 5);

        // Accumulate -7 onto 5.
        submit(3, 1'b0, splat(-7), 1'b1, 1'b0, 1'b0, lc);
        chk_int("accum_ready_low", lc, 2);
        drain(0, 1'b0, cyc, acc);
        for (int i = 0; i < LANES; i++) chk_int("word3_accum_lane", lane_of(drained[3], i), -2);

        // Saturation at both rails.
        v = splat(0);
        v[0] = 262000;
        v[1] = -262100;
        submit(5, 1'b1, v, 1'b1, 1'b0, 1'b0, lc);
        v = splat(1);
        v[0] = 200;
        v[1] = -100;
        submit(5, 1'b0, v, 1'b1, 1'b0, 1'b0, lc);
        chk("sat_flag_set", W'(bus.sat_flag), W'(1));
        drain(0, 1'b0, cyc, acc);
        chk("sat_flag_cleared_by_drain", W'(bus.sat_flag), W'(0));
        chk_int("sat_lane0_max", lane_of(drained[5], 0), 262143);
        chk_int("sat_lane1_min", lane_of(drained[5], 1), -262144);
        chk_int("sat_lane2_plain", lane_of(drained[5], 2), 1);

        // Preload value = address, drain with stalls.
        for (int e = 0; e < DEPTH; e++) submit(e, 1'b1, splat(e), 1'b1, 1'b0, 1'b0, lc);
        drain(1, 1'b0, cyc, acc);
        for (int e = 0; e < DEPTH; e++) chk_int("preload_order", lane_of(drained[e], 0), e);

        // drain_start and in_valid together: drain wins, request waits.
        bus.in_valid = 1'b1;
        bus.in_first = 1'b1;
        bus.in_addr  = ADDR_W'(7);
        bus.in_data  = pack(splat(9));
        drain(0, 1'b1, cyc, acc);
        chk_int("req_blocked_during_drain", acc, 0);
        chk_int("drain_cycles_with_req", cyc, 32);
        chk("in_ready_after_drain_done", W'(bus.in_ready), W'(1));
        submit(7, 1'b1, splat(9), 1'b1, 1'b0, 1'b0, lc);

        // drain_start during RD is ignored.
        submit(7, 1'b0, splat(3), 1'b1, 1'b1, 1'b0, lc);
        chk_int("drain_in_rd_ready_low", lc, 2);

        // Reset while in RD drops the request; it is then re-presented.
        submit(2, 1'b0, splat(11), 1'b0, 1'b0, 1'b1, lc);
        submit(2, 1'b0, splat(11), 1'b1, 1'b0, 1'b0, lc);
        drain(0, 1'b0, cyc, acc);
        chk_int("reset_rd_entry_once", lane_of(drained[2], 3), 13);
        chk_int("drain_ignored_entry7", lane_of(drained[7], 0), 12);

        // Random traffic.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 30; k++) begin
                int  a;
                bit  f;
                a = int'($urandom_range(0, DEPTH - 1));
                f = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < LANES; i++) v[i] = rnd_lane();
                submit(a, f, v, 1'b1, 1'b0, 1'b0, lc);
                chk_int("rand_ready_low", lc, f ? 1 : 2);
            end
            drain(2, 1'b0, cyc, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
